// File: rtl/sccb_req_arbiter.sv
// Shares one SCCB engine between NUM_REQ requesters: one-transaction grants, NACK retry, BUSY timeout.
// Round-robin by default; define SCCB_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins).
module sccb_req_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int MAX_RETRY      = 3,
  parameter int TIMEOUT_CYCLES = 2_000_000
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NUM_REQ-1:0]   req_i,
  input  logic [NUM_REQ-1:0]   req_rw_i,
  input  logic [16*NUM_REQ-1:0] req_data_i,
  output logic [NUM_REQ-1:0]   gnt_o,
  output logic [NUM_REQ-1:0]   done_o,
  output logic                 err_o,
  output logic [7:0]           rdata_o,
  input  logic                 eng_pulse_i,
  output logic                 eng_start_o,
  output logic                 eng_rw_o,
  output logic [15:0]          eng_data_o,
  input  logic                 eng_done_i,
  input  logic                 eng_ack_error_i,
  input  logic [7:0]           eng_rdata_i
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT_ACC, S_BUSY, S_CHECK, S_RELEASE
  } state_t;

  state_t               r_state;
  logic [NUM_REQ-1:0]   r_gnt;
  logic [NUM_REQ-1:0]   r_done;
  logic                 r_err;
  logic [7:0]           r_rdata;
  logic                 r_eng_start;
  logic                 r_eng_rw;
  logic [15:0]          r_eng_data;
  logic [2:0]           r_retry;
  logic [TW-1:0]        r_tmo;

  logic                 w_found;
  logic [PW-1:0]        w_pick;
  logic [NUM_REQ-1:0]   w_onehot;
  logic                 w_rw;
  logic [15:0]          w_data;

`ifdef SCCB_ARB_FIXED_PRIO_EN
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        w_found = 1'b1;
        w_pick  = PW'(i);
      end
    end
  end
`else
  logic [PW-1:0] r_ptr;
  logic          w_hi_found;
  logic [PW-1:0] w_hi;
  logic [PW-1:0] w_lo;

  // Lowest requester above the pointer wins; otherwise wrap to the lowest overall.
  always_comb begin
    w_found    = 1'b0;
    w_hi_found = 1'b0;
    w_hi       = '0;
    w_lo       = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        w_found = 1'b1;
        w_lo    = PW'(i);
        if (PW'(i) > r_ptr) begin
          w_hi_found = 1'b1;
          w_hi       = PW'(i);
        end
      end
    end
    w_pick = w_hi_found ? w_hi : w_lo;
  end
`endif

  always_comb begin
    w_rw   = 1'b0;
    w_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (PW'(i) == w_pick) begin
        w_rw   = req_rw_i[i];
        w_data = req_data_i[16*i +: 16];
      end
    end
  end

  assign w_onehot = NUM_REQ'(1) << w_pick;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state     <= S_IDLE;
      r_gnt       <= '0;
      r_done      <= '0;
      r_err       <= 1'b0;
      r_rdata     <= '0;
      r_eng_start <= 1'b0;
      r_eng_rw    <= 1'b0;
      r_eng_data  <= '0;
      r_retry     <= '0;
      r_tmo       <= '0;
`ifndef SCCB_ARB_FIXED_PRIO_EN
      r_ptr       <= PW'(NUM_REQ - 1);
`endif
    end else begin
      r_done <= '0;
      case (r_state)
        S_IDLE: begin
          r_tmo <= '0;
          if (w_found) begin
            r_gnt      <= w_onehot;
            r_eng_rw   <= w_rw;
            r_eng_data <= w_data;
`ifndef SCCB_ARB_FIXED_PRIO_EN
            r_ptr      <= w_pick;
`endif
            r_state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_tmo <= '0;
          if (eng_pulse_i && eng_done_i) begin
            r_eng_start <= 1'b1;
            r_state     <= S_WAIT_ACC;
          end
        end
        S_WAIT_ACC, S_BUSY: begin
          if (r_tmo == TW'(TIMEOUT_CYCLES - 1)) begin
            // Stuck engine: abort without retry and report the failure.
            r_eng_start <= 1'b0;
            r_done      <= r_gnt;
            r_err       <= 1'b1;
            r_rdata     <= '0;
            r_state     <= S_RELEASE;
          end else begin
            r_tmo <= r_tmo + 1'b1;
            if (eng_pulse_i) begin
              if (r_state == S_WAIT_ACC && !eng_done_i) begin
                r_state <= S_BUSY;
              end else if (r_state == S_BUSY && eng_done_i) begin
                r_eng_start <= 1'b0;
                r_state     <= S_CHECK;
              end
            end
          end
        end
        S_CHECK: begin
          if (eng_ack_error_i && (r_retry < 3'(MAX_RETRY))) begin
            r_retry <= r_retry + 1'b1;
            r_state <= S_ISSUE;
          end else begin
            r_done  <= r_gnt;
            r_err   <= eng_ack_error_i;
            r_rdata <= eng_rdata_i;
            r_state <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          r_gnt   <= '0;
          r_err   <= 1'b0;
          r_retry <= '0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign gnt_o       = r_gnt;
  assign done_o      = r_done;
  assign err_o       = r_err;
  assign rdata_o     = r_rdata;
  assign eng_start_o = r_eng_start;
  assign eng_rw_o    = r_eng_rw;
  assign eng_data_o  = r_eng_data;

endmodule

// File: tb/tb_sccb_req_arbiter.sv
// Bench for sccb_req_arbiter: directed scenarios plus randomized traffic against a rule-level model and engine model.
module tb_sccb_req_arbiter;
  localparam int N  = 2;
  localparam int MR = 3;
  localparam int TO = 1000;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic            rst_i;
  logic [N-1:0]    req_i, req_rw_i;
  logic [16*N-1:0] req_data_i;
  logic [N-1:0]    gnt_o, done_o;
  logic            err_o;
  logic [7:0]      rdata_o;
  logic            eng_pulse_i, eng_start_o, eng_rw_o;
  logic [15:0]     eng_data_o;
  logic            eng_done_i, eng_ack_error_i;
  logic [7:0]      eng_rdata_i;

  sccb_req_arbiter #(.NUM_REQ(N), .MAX_RETRY(MR), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .req_rw_i(req_rw_i),
    .req_data_i(req_data_i), .gnt_o(gnt_o), .done_o(done_o), .err_o(err_o),
    .rdata_o(rdata_o), .eng_pulse_i(eng_pulse_i), .eng_start_o(eng_start_o),
    .eng_rw_o(eng_rw_o), .eng_data_o(eng_data_o), .eng_done_i(eng_done_i),
    .eng_ack_error_i(eng_ack_error_i), .eng_rdata_i(eng_rdata_i)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int m_ptr;
  int nack_target, busy_len, base;
  logic [7:0] rd_val;
  bit stuck;
  logic e_busy, e_armed;
  int e_cnt, eng_attempts;

  always @(posedge clk_i) cyc <= cyc + 1;
  always @(negedge clk_i) eng_pulse_i = ($urandom_range(0, 2) == 0);

  // Engine model: done level high when idle; accepts a start only after seeing it low once.
  always @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      eng_done_i <= 1'b1; eng_ack_error_i <= 1'b0; eng_rdata_i <= '0;
      e_busy <= 1'b0; e_armed <= 1'b1; e_cnt <= 0; eng_attempts <= 0;
    end else if (eng_pulse_i) begin
      if (!eng_start_o) e_armed <= 1'b1;
      if (!e_busy) begin
        if (eng_start_o && e_armed) begin
          e_busy <= 1'b1; e_armed <= 1'b0; eng_done_i <= 1'b0;
          eng_ack_error_i <= 1'b0; e_cnt <= busy_len; eng_attempts <= eng_attempts + 1;
        end
      end else if (stuck) begin
        if (!eng_start_o) begin e_busy <= 1'b0; eng_done_i <= 1'b1; end
      end else if (e_cnt == 0) begin
        e_busy <= 1'b0; eng_done_i <= 1'b1;
        eng_ack_error_i <= ((eng_attempts - base) <= nack_target);
        eng_rdata_i <= rd_val;
      end else begin
        e_cnt <= e_cnt - 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Grant rule straight from the arbitration policy.
  function automatic int pick(input logic [N-1:0] m);
    logic [N-1:0] t;
    int k;
    pick = -1;
`ifdef SCCB_ARB_FIXED_PRIO_EN
    for (int i = N - 1; i >= 0; i--) begin
      t = m >> i;
      if (t[0]) pick = i;
    end
`else
    for (int i = N; i >= 1; i--) begin
      k = (m_ptr + i) % N;
      t = m >> k;
      if (t[0]) pick = k;
    end
`endif
  endfunction

  task automatic set_req(input int k, input logic rw, input logic [15:0] d);
    req_rw_i[k +: 1]    = rw;
    req_data_i[16*k +: 16] = d;
  endtask

  task automatic do_txn(input int nacks, input int blen, input logic [7:0] rdv, input bit drop);
    int g, w, exp_att;
    logic [N-1:0] oh;
    logic [15:0] exp_d;
    logic exp_rw;
    bit seen;
    g = pick(req_i);
    oh = '0; oh[g +: 1] = 1'b1;
    exp_d = req_data_i[16*g +: 16];
    exp_rw = req_rw_i[g +: 1];
    nack_target = nacks; busy_len = blen; rd_val = rdv; base = eng_attempts;
    exp_att = (nacks > MR) ? MR + 1 : nacks + 1;
    seen = 0;
    for (w = 0; w < 3000 && !seen; w++) begin
      @(negedge clk_i);
      if (gnt_o != 0) seen = 1;
    end
    chk("gnt_wait", 32'(seen), 1);
    chk("gnt", 32'(gnt_o), 32'(oh));
    chk("eng_data", 32'(eng_data_o), 32'(exp_d));
    chk("eng_rw", 32'(eng_rw_o), 32'(exp_rw));
    seen = 0;
    for (w = 0; w < 5000 && !seen; w++) begin
      @(negedge clk_i);
      if (done_o != 0) seen = 1;
    end
    chk("done_wait", 32'(seen), 1);
    chk("done", 32'(done_o), 32'(oh));
    chk("gnt_at_done", 32'(gnt_o), 32'(oh));
    chk("err", 32'(err_o), 32'(nacks > MR));
    chk("starts", 32'(eng_attempts - base), 32'(exp_att));
    if (exp_rw) chk("rdata", 32'(rdata_o), 32'(rdv));
    m_ptr = g;
    if (drop) req_i[g +: 1] = 1'b0;
    else set_req(g, 1'($urandom), 16'($urandom));
    @(negedge clk_i);
    chk("done_single", 32'(done_o), 0);
    chk("gnt_released", 32'(gnt_o), 0);
  endtask

  initial begin
    int t0, w;
    bit seen;
    rst_i = 1'b0; req_i = '0; req_rw_i = '0; req_data_i = '0;
    stuck = 0; nack_target = 0; busy_len = 2; rd_val = '0; base = 0; m_ptr = N - 1;
    repeat (3) @(negedge clk_i);
    chk("reset_outs", {gnt_o, done_o, err_o, rdata_o, eng_start_o, eng_rw_o, eng_data_o}, 0);
    rst_i = 1'b1;
    @(negedge clk_i);

    // Single write from requester 0
    set_req(0, 1'b0, 16'h1280); req_i = 2'b01;
    do_txn(0, 3, 8'h00, 1);

    // Both requesters held: grants alternate
    set_req(0, 1'b0, 16'h1111); set_req(1, 1'b0, 16'h2222); req_i = 2'b11;
    repeat (4) do_txn(0, 1, 8'h00, 0);
    req_i = '0;
    @(negedge clk_i);

    // NACK retries: recovered, then exhausted
    set_req(0, 1'b0, 16'h3A5C); req_i = 2'b01;
    do_txn(2, 1, 8'h00, 1);
    set_req(0, 1'b0, 16'h3A5D); req_i = 2'b01;
    do_txn(4, 1, 8'h00, 1);

    // Read returns data that stays on rdata_o
    set_req(1, 1'b1, 16'h0A00); req_i = 2'b10;
    do_txn(0, 2, 8'h76, 1);
    repeat (5) @(negedge clk_i);
    chk("rdata_hold", 32'(rdata_o), 32'h76);

    // Engine never finishes: timeout abort
    stuck = 1; set_req(0, 1'b0, 16'h3344); req_i = 2'b01;
    seen = 0;
    for (w = 0; w < 3000 && !seen; w++) begin
      @(negedge clk_i);
      if (eng_start_o) seen = 1;
    end
    chk("tmo_start_wait", 32'(seen), 1);
    t0 = cyc; seen = 0;
    for (w = 0; w < 1500 && !seen; w++) begin
      @(negedge clk_i);
      if (done_o != 0) seen = 1;
    end
    chk("tmo_done_wait", 32'(seen), 1);
    chk("tmo_latency", 32'(cyc - t0), 32'(TO));
    chk("tmo_done", 32'(done_o), 32'b01);
    chk("tmo_err", 32'(err_o), 1);
    chk("tmo_rdata", 32'(rdata_o), 0);
    chk("tmo_start_low", 32'(eng_start_o), 0);
    m_ptr = 0; req_i = '0; stuck = 0;
    @(negedge clk_i);
    set_req(1, 1'b0, 16'h5566); req_i = 2'b10;
    do_txn(0, 2, 8'h00, 1);

    // Reset during a long transaction from requester 0
    busy_len = 40; set_req(0, 1'b0, 16'h7788); req_i = 2'b01;
    seen = 0;
    for (w = 0; w < 3000 && !seen; w++) begin
      @(negedge clk_i);
      if (eng_start_o && !eng_done_i) seen = 1;
    end
    chk("busy_wait", 32'(seen), 1);
    repeat (8) @(negedge clk_i);
    @(posedge clk_i);
    #2 rst_i = 1'b0;
    #1 chk("rst_mid_outs", {gnt_o, done_o, err_o, rdata_o, eng_start_o, eng_rw_o, eng_data_o}, 0);
    set_req(1, 1'b0, 16'h99AA); req_i = 2'b11; m_ptr = N - 1;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
    do_txn(0, 2, 8'h00, 1);
    do_txn(0, 2, 8'h00, 1);

    // Randomized traffic
    for (int t = 0; t < 30; t++) begin
      if (req_i == 0) begin
        for (int k = 0; k < N; k++) set_req(k, 1'($urandom), 16'($urandom));
        req_i = N'($urandom_range(1, (1 << N) - 1));
      end
      do_txn($urandom_range(0, 5), $urandom_range(0, 6), 8'($urandom), bit'($urandom_range(0, 1)));
    end
    req_i = '0;
    repeat (3) @(negedge clk_i);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sccb_req_arbiter.md
Name: sccb_req_arbiter

Overview:
- Shares one SCCB transaction engine (camSCCBCtrl-style: start/rw/16-bit addr+data in, level done, ack_error, 8-bit read data out) between NUM_REQ requesters.
- Example requesters: the power-up camera setup sequencer and a runtime exposure/gain tuner.
- Grants round-robin, holds each grant for exactly one transaction, retries on NACK and aborts on timeout.
- Sits between the requesters and the single SCCB engine instance driving sioc/siod.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
MAX_RETRY, 3, extra attempts after an ack error before reporting failure (0..7)
TIMEOUT_CYCLES, 2_000_000, clk_i cycles allowed in BUSY before abort (40 ms at 50 MHz)

Ports:
clk_i  in  1  main clock
rst_i  in  1  reset
req_i  in  NUM_REQ  request level per requester; held until its done_o pulse
req_rw_i  in  NUM_REQ  per requester: 1 = read, 0 = write
req_data_i  in  16*NUM_REQ  per requester {reg_addr, wr_data}; requester k uses bits [16k+15:16k]
gnt_o  out  NUM_REQ  one-hot grant, high for the whole transaction
done_o  out  NUM_REQ  one-cycle completion pulse to the granted requester
err_o  out  1  valid with done_o: 1 = retries exhausted or timeout
rdata_o  out  8  read data, valid with done_o when req_rw_i = 1
eng_pulse_i  in  1  SCCB data_pulse strobe; all engine-facing state changes occur only on cycles where it is high
eng_start_o  out  1  engine start
eng_rw_o  out  1  engine r/w
eng_data_o  out  16  engine address/data
eng_done_i  in  1  engine done level
eng_ack_error_i  in  1  engine NACK flag, valid while eng_done_i = 1
eng_rdata_i  in  8  engine read data

Behaviour:
- Reset rst_i: asynchronous, active-low; clock clk_i.
- Reset values: gnt_o = 0, done_o = 0, err_o = 0, rdata_o = 0, eng_start_o = 0, eng_rw_o = 0, eng_data_o = 0. State IDLE, retry count 0, timeout count 0, RR pointer = NUM_REQ-1 so requester 0 wins first.
- State machine:
  - IDLE: on any clk with req_i != 0, grant the first requester with req_i set, searching upward from pointer+1 with wrap. Latch its rw/data into eng_rw_o/eng_data_o, set gnt_o and pointer, go ISSUE. Arbitration takes 1 clk and does not wait for eng_pulse_i.
  - ISSUE: on eng_pulse_i with eng_done_i = 1, assert eng_start_o and go WAIT_ACC.
  - WAIT_ACC: on eng_pulse_i with eng_done_i = 0, go BUSY (eng_start_o stays high).
  - BUSY: on eng_pulse_i with eng_done_i = 1, deassert eng_start_o and go CHECK.
  - CHECK: next clk.
    - If eng_ack_error_i = 1 and retry count < MAX_RETRY: increment retry count, go ISSUE.
    - Otherwise: pulse done_o of the granted requester, set err_o = eng_ack_error_i, capture rdata_o = eng_rdata_i, go RELEASE.
  - RELEASE: 1 clk. Clear gnt_o, err_o and retry count; go IDLE. Back-to-back grants are separated by at least 2 clk.
- Timeout: the counter runs in WAIT_ACC and BUSY and clears on entry to ISSUE. At TIMEOUT_CYCLES: deassert eng_start_o, pulse done_o with err_o = 1 and rdata_o = 0, go RELEASE. There is no retry on timeout.
- Grant is never pre-empted. A req_i drop mid-transaction is ignored: the transaction completes and done_o still pulses.
- Simultaneous new requests during a grant are queued by their held req_i only; no internal FIFO.
- rdata_o holds its value until the next completion.
- eng_data_o and eng_rw_o are stable from grant until RELEASE.
- Reset mid-transaction aborts immediately. eng_start_o drops asynchronously; the engine shares rst_i, so it also resets.
- Latency, idle bus, single write, no NACK: 1 clk grant + ISSUE/WAIT_ACC/BUSY pulse waits + 1 clk CHECK, then done_o.

Optional Feature:
- SCCB_ARB_FIXED_PRIO_EN defined: arbitration is fixed priority, lowest index wins; the RR pointer is removed. Requester 0 (setup sequencer) always preempts queued runtime requests at the grant point.
- Undefined: round-robin as above.

Test Plan:
- Reset, req_i = 01, write 16'h1280, engine model ACKs → gnt_o = 01, eng_data_o = 16'h1280, eng_rw_o = 0; exactly one done_o = 01 pulse with err_o = 0; gnt_o returns to 0.
- req_i = 11 held continuously, 4 transactions → grants alternate 01, 10, 01, 10 (fixed-prio build: 01 four times while req0 held).
- Engine NACKs 2 times then ACKs, MAX_RETRY = 3 → eng_start_o asserted 3 times, done_o with err_o = 0. NACK 4 times → 4 starts, done_o with err_o = 1.
- Read request req_rw_i = 1, data 16'h0A00, engine returns 8'h76 → rdata_o = 8'h76 with done_o and held afterwards.
- Engine eng_done_i stuck 0 after start, TIMEOUT_CYCLES = 1000 → done_o + err_o = 1 at 1000 clk after WAIT_ACC entry, eng_start_o = 0, next request granted normally.
- rst_i low while in BUSY → all outputs 0 on the same edge; after release, a pending req_i = 10 is granted 10 first only if the pointer was reset (expect 01 wins if both requesters are pending).
